// File: rtl/alu_op_sequencer_pkg.sv
// Shared encodings for the ALU op sequencer: instruction fields, FSM states,
// datapath select codes and the per-state control word.
package alu_op_sequencer_pkg;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b01;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WRITE_REG,
    S_WRITE_IMM
  } state_e;

  typedef enum logic [2:0] {
    CLS_MOV_IMM,
    CLS_MOV_REG,
    CLS_ADD,
    CLS_CMP,
    CLS_AND,
    CLS_MVN,
    CLS_ILLEGAL
  } instr_cls_e;

  typedef struct packed {
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] alu_op;
    logic [1:0] shift;
    logic       done;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Control word presented while the FSM sits in state s with instruction class c.
  function automatic ctrl_t state_ctrl(state_e s, instr_cls_e c,
                                       logic [1:0] aop, logic [1:0] sh);
    ctrl_t r;
    r = CTRL_IDLE;
    case (s)
      S_DECODE: begin
        r.illegal = (c == CLS_ILLEGAL);
        r.done    = (c == CLS_ILLEGAL);
      end
      S_GET_A: begin
        r.nsel  = NSEL_RN;
        r.loada = 1'b1;
      end
      S_GET_B: begin
        r.nsel  = NSEL_RM;
        r.loadb = 1'b1;
        r.shift = sh;
      end
      S_EXEC: begin
        r.shift  = sh;
        r.alu_op = aop;
        r.asel   = (c == CLS_MOV_REG) || (c == CLS_MVN);
        r.loadc  = (c != CLS_CMP);
        r.loads  = (c == CLS_CMP);
        r.done   = (c == CLS_CMP);
      end
      S_WRITE_REG: begin
        r.nsel  = NSEL_RD;
        r.vsel  = VSEL_C;
        r.write = 1'b1;
        r.done  = 1'b1;
      end
      S_WRITE_IMM: begin
        r.nsel  = NSEL_RN;
        r.vsel  = VSEL_IMM;
        r.write = 1'b1;
        r.done  = 1'b1;
      end
      default: r = CTRL_IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Fetch-side handshake plus the datapath control strobes of the ALU op sequencer.
interface alu_op_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic [2:0]        nsel;
  logic [1:0]        vsel;
  logic              write;
  logic              loada;
  logic              loadb;
  logic              loadc;
  logic              loads;
  logic              asel;
  logic              bsel;
  logic [1:0]        alu_op;
  logic [1:0]        shift;
  logic [DATA_W-1:0] sximm;
  logic              done;
  logic              illegal;

  modport master (
    output instr_valid, instr,
    input  instr_ready, nsel, vsel, write, loada, loadb, loadc, loads,
           asel, bsel, alu_op, shift, sximm, done, illegal
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, nsel, vsel, write, loada, loadb, loadc, loads,
           asel, bsel, alu_op, shift, sximm, done, illegal
  );
endinterface

// File: rtl/alu_instr_decoder.sv
// Combinational classifier: instruction fields to class, ALU operation and
// sign-extended immediate.
module alu_instr_decoder
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8
) (
  input  logic [2:0]        opcode_i,
  input  logic [1:0]        op_i,
  input  logic [IMM_W-1:0]  imm_i,
  output instr_cls_e        cls_o,
  output logic [1:0]        alu_op_o,
  output logic [DATA_W-1:0] sximm_o
);

  always_comb begin
    cls_o    = CLS_ILLEGAL;
    alu_op_o = ALU_ADD;
    if (opcode_i == OPC_MOV) begin
      if (op_i == OP_MOV_IMM) begin
        cls_o = CLS_MOV_IMM;
      end else if (op_i == OP_MOV_REG) begin
        cls_o = CLS_MOV_REG;
      end
    end else if (opcode_i == OPC_ALU) begin
      case (op_i)
        OP_ADD: begin
          cls_o    = CLS_ADD;
          alu_op_o = ALU_ADD;
        end
        OP_CMP: begin
          cls_o    = CLS_CMP;
          alu_op_o = ALU_SUB;
        end
        OP_AND: begin
          cls_o    = CLS_AND;
          alu_op_o = ALU_AND;
        end
        default: begin
          cls_o    = CLS_MVN;
          alu_op_o = ALU_NOTB;
        end
      endcase
    end
  end

  assign sximm_o = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle control FSM for the 16-bit ALU datapath. Outputs are registered
// from the next state so nothing combinational runs from the instruction inputs.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  alu_op_sequencer_if.slave  bus
);

  state_e            state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic              instr_ready_q;
  logic [DATA_W-1:0] sximm_q, sximm_d;
  instr_cls_e        cls_d;
  logic [1:0]        alu_op_d;

  // Outside WAIT the latched word recirculates, so decoding instr_d also
  // decodes the instruction currently being sequenced.
  assign instr_d = (state_q == S_WAIT && bus.instr_valid) ? bus.instr : instr_q;

  alu_instr_decoder #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_decoder (
    .opcode_i (instr_d[15:13]),
    .op_i     (instr_d[12:11]),
    .imm_i    (instr_d[IMM_W-1:0]),
    .cls_o    (cls_d),
    .alu_op_o (alu_op_d),
    .sximm_o  (sximm_d)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:      if (bus.instr_valid) state_d = S_DECODE;
      S_DECODE: begin
        case (cls_d)
          CLS_MOV_IMM:          state_d = S_WRITE_IMM;
          CLS_MOV_REG, CLS_MVN: state_d = S_GET_B;
          CLS_ADD, CLS_AND,
          CLS_CMP:              state_d = S_GET_A;
          default:              state_d = S_WAIT;
        endcase
      end
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_EXEC;
      S_EXEC:      state_d = (cls_d == CLS_CMP) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      S_WRITE_IMM: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  assign ctrl_d = state_ctrl(state_d, cls_d, alu_op_d, instr_d[4:3]);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_WAIT;
      instr_q       <= '0;
      ctrl_q        <= CTRL_IDLE;
      instr_ready_q <= 1'b1;
      sximm_q       <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      ctrl_q        <= ctrl_d;
      instr_ready_q <= (state_d == S_WAIT);
      sximm_q       <= sximm_d;
    end
  end

  assign bus.instr_ready = instr_ready_q;
  assign bus.nsel        = ctrl_q.nsel;
  assign bus.vsel        = ctrl_q.vsel;
  assign bus.asel        = ctrl_q.asel;
  assign bus.bsel        = ctrl_q.bsel;
  assign bus.alu_op      = ctrl_q.alu_op;
  assign bus.shift       = ctrl_q.shift;
  assign bus.sximm       = sximm_q;

  // Strobes are gated by reset so an asserted reset never lets a write or load through.
  assign bus.write   = ctrl_q.write   & reset_n;
  assign bus.loada   = ctrl_q.loada   & reset_n;
  assign bus.loadb   = ctrl_q.loadb   & reset_n;
  assign bus.loadc   = ctrl_q.loadc   & reset_n;
  assign bus.loads   = ctrl_q.loads   & reset_n;
  assign bus.done    = ctrl_q.done    & reset_n;
  assign bus.illegal = ctrl_q.illegal & reset_n;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer against a table-driven model of the
// instruction sequences.
module tb_alu_op_sequencer;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  alu_op_sequencer_if #(.DATA_W(16)) bus();

  alu_op_sequencer #(.DATA_W(16), .IMM_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] cap_obs [0:11];
  logic [15:0] cap_sx  [0:11];
  int          cap_lat;

  function automatic logic [18:0] pk(logic [2:0] nsel, logic [1:0] vsel,
      logic w, logic la, logic lb, logic lc, logic ls, logic as, logic bs,
      logic [1:0] aop, logic [1:0] sh, logic dn, logic il, logic rdy);
    return {nsel, vsel, w, la, lb, lc, ls, as, bs, aop, sh, dn, il, rdy};
  endfunction

  function automatic logic [18:0] obs_now();
    return pk(bus.nsel, bus.vsel, bus.write, bus.loada, bus.loadb, bus.loadc,
              bus.loads, bus.asel, bus.bsel, bus.alu_op, bus.shift, bus.done,
              bus.illegal, bus.instr_ready);
  endfunction

  // Step letters: D decode, A get A, B get B, X execute, W write C, I write imm.
  function automatic string model_seq(logic [15:0] ins);
    logic [2:0] opc;
    logic [1:0] op;
    opc = ins[15:13];
    op  = ins[12:11];
    if (opc == 3'b110 && op == 2'b10) return "DI";
    if (opc == 3'b110 && op == 2'b00) return "DBXW";
    if (opc == 3'b101) begin
      case (op)
        2'b00:   return "DABXW";
        2'b01:   return "DABX";
        2'b10:   return "DABXW";
        default: return "DBXW";
      endcase
    end
    return "D";
  endfunction

  function automatic int model_len(logic [15:0] ins);
    string s;
    s = model_seq(ins);
    return s.len();
  endfunction

  function automatic logic [15:0] model_sximm(logic [15:0] ins);
    int v;
    v = int'(ins[7:0]);
    if (v >= 128) v = v - 256;
    return 16'(v);
  endfunction

  // Expected outputs k cycles after the accepting edge; k = len+1 is back in WAIT.
  function automatic logic [18:0] model_step(logic [15:0] ins, int k);
    string s;
    byte   ch;
    int    n;
    logic  is_alu, is_cmp, is_ill, zero_a, dn;
    logic [1:0] aop, sh;
    s      = model_seq(ins);
    n      = s.len();
    is_alu = (ins[15:13] == 3'b101);
    is_cmp = is_alu && (ins[12:11] == 2'b01);
    is_ill = (n == 1);
    zero_a = (n == 4) && !is_cmp;
    sh     = ins[4:3];
    if (k > n) return pk(3'b000, 2'b00, 0,0,0,0,0,0,0, 2'b00, 2'b00, 0, 0, 1);
    ch = s[k-1];
    dn = (k == n);
    aop = 2'b00;
    if (is_alu) begin
      case (ins[12:11])
        2'b01:   aop = 2'b01;
        2'b10:   aop = 2'b10;
        2'b11:   aop = 2'b11;
        default: aop = 2'b00;
      endcase
    end
    case (ch)
      "A": return pk(3'b001, 2'b00, 0,1,0,0,0,0,0, 2'b00, 2'b00, dn, 0, 0);
      "B": return pk(3'b100, 2'b00, 0,0,1,0,0,0,0, 2'b00, sh, dn, 0, 0);
      "X": return pk(3'b000, 2'b00, 0,0,0,!is_cmp,is_cmp,zero_a,0, aop, sh, dn, 0, 0);
      "W": return pk(3'b010, 2'b00, 1,0,0,0,0,0,0, 2'b00, 2'b00, dn, 0, 0);
      "I": return pk(3'b001, 2'b01, 1,0,0,0,0,0,0, 2'b00, 2'b00, dn, 0, 0);
      default: return pk(3'b000, 2'b00, 0,0,0,0,0,0,0, 2'b00, 2'b00, dn, is_ill, 0);
    endcase
  endfunction

  // Offers one instruction from WAIT and records every cycle up to the one after done.
  task automatic capture(input logic [15:0] ins);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'($urandom);
    cap_lat = 0;
    for (int k = 1; k <= 9; k++) begin
      cap_obs[k] = obs_now();
      cap_sx[k]  = bus.sximm;
      if (cap_lat != 0) break;
      if (bus.done) cap_lat = k;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset_n         = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr       = 16'hD1FB;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.done, bus.illegal} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 0000000",
               {bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.done, bus.illegal});
    end
    n_checks++;
    if (cap_sx[0] !== cap_sx[0] || bus.sximm !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_sximm: got %h expected 0000", bus.sximm);
    end
    bus.instr_valid = 1'b0;
    reset_n         = 1'b1;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (obs_now() !== model_step(16'h0000, 2)) begin
        n_fail++;
        $display("FAIL reset_idle c%0d: got %h expected %h", c, obs_now(), model_step(16'h0000, 2));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mov_imm();
    logic [15:0] ins;
    ins = 16'hD1FB;
    capture(ins);
    n_checks++;
    if (cap_lat !== 2) begin
      n_fail++;
      $display("FAIL mov_imm_latency: got %0d expected 2", cap_lat);
    end
    for (int k = 1; k <= 3; k++) begin
      n_checks++;
      if (cap_obs[k] !== model_step(ins, k)) begin
        n_fail++;
        $display("FAIL mov_imm cycle %0d: got %h expected %h", k, cap_obs[k], model_step(ins, k));
      end
    end
    n_checks++;
    if (cap_sx[2] !== 16'hFFFB) begin
      n_fail++;
      $display("FAIL mov_imm_sximm: got %h expected fffb", cap_sx[2]);
    end
  endtask

  task automatic test_add();
    logic [15:0] ins;
    ins = 16'hA148;
    capture(ins);
    n_checks++;
    if (cap_lat !== 5) begin
      n_fail++;
      $display("FAIL add_latency: got %0d expected 5", cap_lat);
    end
    for (int k = 1; k <= 6; k++) begin
      n_checks++;
      if (cap_obs[k] !== model_step(ins, k)) begin
        n_fail++;
        $display("FAIL add cycle %0d: got %h expected %h", k, cap_obs[k], model_step(ins, k));
      end
    end
  endtask

  task automatic test_cmp();
    logic [15:0] ins;
    ins = 16'hA900;
    capture(ins);
    n_checks++;
    if (cap_lat !== 4) begin
      n_fail++;
      $display("FAIL cmp_latency: got %0d expected 4", cap_lat);
    end
    for (int k = 1; k <= 5; k++) begin
      n_checks++;
      if (cap_obs[k] !== model_step(ins, k)) begin
        n_fail++;
        $display("FAIL cmp cycle %0d: got %h expected %h", k, cap_obs[k], model_step(ins, k));
      end
    end
  endtask

  task automatic test_illegal();
    logic [15:0] ins;
    ins = 16'hE000;
    capture(ins);
    n_checks++;
    if (cap_lat !== 1) begin
      n_fail++;
      $display("FAIL illegal_latency: got %0d expected 1", cap_lat);
    end
    for (int k = 1; k <= 2; k++) begin
      n_checks++;
      if (cap_obs[k] !== model_step(ins, k)) begin
        n_fail++;
        $display("FAIL illegal cycle %0d: got %h expected %h", k, cap_obs[k], model_step(ins, k));
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    bus.instr       = 16'hA148;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (bus.loadc !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_exec_loadc: got %b expected 1", bus.loadc);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.done, bus.illegal} !== 7'b0) begin
      n_fail++;
      $display("FAIL midreset_gated: got %b expected 0000000",
               {bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.done, bus.illegal});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    n_checks++;
    if (obs_now() !== model_step(16'h0000, 2) || bus.sximm !== 16'h0000) begin
      n_fail++;
      $display("FAIL midreset_wait: got %h/%h expected %h/0000", obs_now(), bus.sximm,
               model_step(16'h0000, 2));
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] mvn, andi;
    logic [18:0] exp;
    logic [15:0] exp_sx;
    mvn  = 16'hB893;
    andi = 16'hB225;
    bus.instr       = mvn;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr = andi;
    for (int c = 1; c <= 11; c++) begin
      exp    = (c <= 5) ? model_step(mvn, c) : model_step(andi, c - 5);
      exp_sx = (c <= 5) ? model_sximm(mvn) : model_sximm(andi);
      n_checks++;
      if (obs_now() !== exp) begin
        n_fail++;
        $display("FAIL b2b cycle %0d: got %h expected %h", c, obs_now(), exp);
      end
      if (c != 5 && c != 11) begin
        n_checks++;
        if (bus.sximm !== exp_sx) begin
          n_fail++;
          $display("FAIL b2b_sximm cycle %0d: got %h expected %h", c, bus.sximm, exp_sx);
        end
      end
      if (c == 6) bus.instr_valid = 1'b0;
      if (c != 11) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_random();
    logic [4:0]  hdr [0:5];
    logic [15:0] ins;
    int          r, n;
    hdr[0] = 5'b11010; hdr[1] = 5'b11000; hdr[2] = 5'b10100;
    hdr[3] = 5'b10101; hdr[4] = 5'b10110; hdr[5] = 5'b10111;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      ins = 16'($urandom);
      r   = int'($urandom_range(0, 7));
      if (r < 6) ins[15:11] = hdr[r];
      n = model_len(ins);
      capture(ins);
      n_checks++;
      if (cap_lat !== n) begin
        n_fail++;
        $display("FAIL rand_latency %h: got %0d expected %0d", ins, cap_lat, n);
      end
      for (int k = 1; k <= n + 1; k++) begin
        n_checks++;
        if (cap_obs[k] !== model_step(ins, k)) begin
          n_fail++;
          $display("FAIL rand %h cycle %0d: got %h expected %h", ins, k, cap_obs[k], model_step(ins, k));
        end
      end
      n_checks++;
      if (cap_sx[n] !== model_sximm(ins)) begin
        n_fail++;
        $display("FAIL rand_sximm %h: got %h expected %h", ins, cap_sx[n], model_sximm(ins));
      end
    end
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    reset_n         = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    cap_lat         = 0;
    for (int i = 0; i < 12; i++) begin
      cap_obs[i] = '0;
      cap_sx[i]  = '0;
    end
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_illegal();
    test_reset_mid_exec();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle control FSM that sequences the 16-bit ALU datapath: register-file reads into A/B, shifter/ALU execute, result capture, status update and write-back.
- Accepts one 16-bit instruction per transaction over a valid/ready handshake and emits all datapath strobes and selects.
- Sits between instruction fetch and the datapath (regfile, A/B/C registers, shifter, ALU, status register).

Parameters:
- DATA_W, 16, datapath width; width of sign-extended immediate output.
- IMM_W, 8, immediate field width (instr[IMM_W-1:0]).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on clk rising edge.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  high only in WAIT; transfer on valid&ready at clk edge.
- instr  in  16  [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] shift, [2:0] Rm.
- nsel  out  3  one-hot regfile port select: 001=Rn, 010=Rd, 100=Rm, 000=none.
- vsel  out  2  write-back source: 00=C register, 01=sximm.
- write  out  1  regfile write strobe.
- loada, loadb, loadc, loads  out  1 each  A/B/C/status register load strobes.
- asel  out  1  1 forces ALU A input to 0.
- bsel  out  1  fixed 0 (shifted B) for this instruction set.
- alu_op  out  2  00 add, 01 sub, 10 and, 11 not-B.
- shift  out  2  shifter control.
- sximm  out  DATA_W  sign-extended instr[IMM_W-1:0] of latched instruction.
- done  out  1  one-cycle pulse in final cycle of each instruction.
- illegal  out  1  one-cycle pulse with done for unsupported encodings.

Behaviour:
- Instruction latched into internal register on accept; all outputs depend only on state and latched instruction. No input-to-output combinational path except reset_n gating.
- Supported: MOV imm (110/10), MOV reg (110/00), ADD (101/00), CMP (101/01), AND (101/10), MVN (101/11). All others are illegal.
- States: WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_REG, WRITE_IMM.
- Sequences, one state per cycle:
  - MOV imm: DECODE > WRITE_IMM > WAIT.
  - MOV reg / MVN: DECODE > GET_B > EXEC > WRITE_REG > WAIT.
  - ADD / AND: DECODE > GET_A > GET_B > EXEC > WRITE_REG > WAIT.
  - CMP: DECODE > GET_A > GET_B > EXEC > WAIT.
  - Illegal: DECODE > WAIT.
- Per-state outputs:
  - GET_A: nsel=001, loada=1.
  - GET_B: nsel=100, loadb=1, shift=instr[4:3].
  - EXEC: shift=instr[4:3]; alu_op per instruction (MOV reg=00); asel=1 for MOV reg and MVN, else 0; loadc=1 except CMP; loads=1 for CMP only; done=1 for CMP.
  - WRITE_REG: nsel=010, vsel=00, write=1, done=1.
  - WRITE_IMM: nsel=001, vsel=01, write=1, done=1.
  - DECODE: illegal=1 and done=1 if unsupported encoding.
- Outputs not listed for a state are 0 (nsel=000, vsel=00, shift=00).
- Latency from accepting edge to done-high cycle: MOV imm 2, MOV reg/MVN 4, ADD/AND 5, CMP 4, illegal 1. instr_ready is high the cycle after done.
- Throughput: no new instruction is accepted before WAIT is re-entered. instr_valid is ignored outside WAIT, and the latched instruction is stable for the whole sequence.
- Reset: reset_n=0 at an edge forces WAIT and clears the latched instruction to 0.
- While reset_n=0, write, loada, loadb, loadc, loads, done and illegal are forced 0 combinationally, so a mid-operation reset never produces a write or load.
- Reset-value outputs: instr_ready=1, all strobes 0, nsel=000, vsel=00, alu_op=00, sximm=0.
- Reset and instr_valid in the same cycle: reset wins; no transfer.

Decomposition:
- Shared package: opcode/op constants, state enum, nsel one-hot codes, vsel codes, alu_op codes.
- One natural sub-module: alu_instr_decoder. It is combinational and maps the latched instruction to an instruction class (mov_imm, mov_reg, add, cmp, and, mvn, illegal), the alu_op and the sximm.

Test Plan:
- Reset, then release with instr_valid=0 -> instr_ready=1, all strobes 0, FSM holds WAIT.
- MOV R1,#-5 (0xD1FB) -> done on cycle 2; WRITE_IMM shows nsel=001, vsel=01, sximm=0xFFFB, write=1.
- ADD R2,R1,R0 LSL#1 (0xA148) -> loada(nsel=001), loadb(nsel=100, shift=01), EXEC alu_op=00 loadc=1, then write nsel=010 vsel=00; done on cycle 5.
- CMP R1,R0 (0xA900) -> EXEC alu_op=01, loads=1, loadc=0, done=1; no write in any cycle.
- Illegal 0xE000 -> cycle 1 done=1 and illegal=1; no strobes; instr_ready=1 next cycle.
- reset_n low during EXEC of ADD -> no loadc or write in that cycle; WAIT next cycle. Back-to-back MVN then AND with instr_valid held high -> second accepted only after the first's done.
